// File: rtl/dec3x8_strobe.sv
// dec3x8_strobe: registered 3-to-8 one-hot decoder with a valid/ready input,
// programmable strobe hold time and a one-entry pending buffer so that
// consecutive strobes run back-to-back without an idle cycle.
module dec3x8_strobe #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] code,
  output logic [7:0] D,
  output logic       busy,
  output logic       done
);

  // Counter reload value: a strobe occupies HOLD_CYCLES cycles, counting down to 0.
  localparam logic [7:0] RELOAD = 8'(HOLD_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t     state_r;
  state_t     state_s;
  logic [7:0] cnt_r;
  logic [7:0] cnt_s;
  logic [7:0] d_r;
  logic [7:0] d_s;
  logic       pend_v_r;
  logic       pend_v_s;
  logic [2:0] pend_code_r;
  logic [2:0] pend_code_s;
  logic       accept_s;
  logic       last_s;

  // Binary index to one-hot; the only way a value is ever loaded onto D.
  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    onehot8 = 8'h01 << idx;
  endfunction

  // Ready depends only on registered state, en and rst, never on in_valid.
  assign in_ready = en && !pend_v_r && !rst;
  assign accept_s = in_valid && in_ready;
  assign last_s   = (cnt_r == 8'd0);

  assign D    = d_r;
  assign busy = (state_r == HOLD);
  assign done = busy && last_s && en;

  // Next-state and next-strobe decision; en low aborts everything.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    d_s         = d_r;
    pend_v_s    = pend_v_r;
    pend_code_s = pend_code_r;
    if (!en) begin
      state_s  = IDLE;
      cnt_s    = 8'd0;
      d_s      = 8'h00;
      pend_v_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            d_s     = onehot8(code);
            cnt_s   = RELOAD;
            state_s = HOLD;
          end else begin
            d_s = 8'h00;
          end
        end
        HOLD: begin
          if (!last_s) begin
            cnt_s = cnt_r - 8'd1;
            if (accept_s) begin
              pend_code_s = code;
              pend_v_s    = 1'b1;
            end else begin
              pend_v_s = pend_v_r;
            end
          end else if (pend_v_r) begin
            // Queued code takes over at the edge after done.
            d_s      = onehot8(pend_code_r);
            cnt_s    = RELOAD;
            pend_v_s = 1'b0;
          end else if (accept_s) begin
            // Direct load in the last cycle, bypassing the pending buffer.
            d_s   = onehot8(code);
            cnt_s = RELOAD;
          end else begin
            d_s     = 8'h00;
            state_s = IDLE;
          end
        end
        default: begin
          state_s  = IDLE;
          cnt_s    = 8'd0;
          d_s      = 8'h00;
          pend_v_s = 1'b0;
        end
      endcase
    end
  end

  // State, counter, strobe and pending-buffer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= 8'd0;
      d_r         <= 8'h00;
      pend_v_r    <= 1'b0;
      pend_code_r <= 3'd0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      d_r         <= d_s;
      pend_v_r    <= pend_v_s;
      pend_code_r <= pend_code_s;
    end
  end

endmodule

// File: tb/tb_dec3x8_strobe.sv
// Directed testbench for dec3x8_strobe: one instance with HOLD_CYCLES=4 and
// one with HOLD_CYCLES=1, sharing clock and reset.
module tb_dec3x8_strobe;

  logic       clk;
  logic       rst;
  logic       en;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] code;
  logic [7:0] d4;
  logic       busy;
  logic       done;

  logic       en1;
  logic       in_valid1;
  logic       in_ready1;
  logic [2:0] code1;
  logic [7:0] d1;
  logic       busy1;
  logic       done1;

  int pass_cnt;
  int total_cnt;

  dec3x8_strobe #(.HOLD_CYCLES(4)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .code(code), .D(d4), .busy(busy), .done(done)
  );

  dec3x8_strobe #(.HOLD_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en1), .in_valid(in_valid1), .in_ready(in_ready1),
    .code(code1), .D(d1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; code = 3'd0;
    en1 = 1'b1; in_valid1 = 1'b0; code1 = 3'd0;
    step();
    step();
    total_cnt++;
    if (d4 !== 8'h00 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_outputs: D=%h busy=%b done=%b, want 00 0 0", d4, busy, done);
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b0)
      $display("FAIL reset_ready: in_ready=%b, want 0", in_ready);
    else pass_cnt++;
    total_cnt++;
    if (d1 !== 8'h00 || busy1 !== 1'b0 || done1 !== 1'b0)
      $display("FAIL reset_outputs_h1: D=%h busy=%b done=%b, want 00 0 0", d1, busy1, done1);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1)
      $display("FAIL reset_release_ready: in_ready=%b, want 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    in_valid = 1'b1; code = 3'd5;
    step();
    in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      total_cnt++;
      if (d4 !== 8'h20 || busy !== 1'b1 || done !== (i == 4))
        $display("FAIL basic_hold cyc%0d: D=%h busy=%b done=%b, want 20 1 %0d", i, d4, busy, done, (i == 4));
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if (d4 !== 8'h00 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL basic_end: D=%h busy=%b done=%b, want 00 0 0", d4, busy, done);
    else pass_cnt++;
  endtask

  task automatic test_all_codes();
    logic [7:0] exp_d;
    for (int c = 0; c < 8; c++) begin
      exp_d = 8'h01 << c;
      in_valid = 1'b1; code = 3'(c);
      step();
      in_valid = 1'b0;
      for (int i = 1; i <= 4; i++) begin
        total_cnt++;
        if (d4 !== exp_d || done !== (i == 4))
          $display("FAIL all_codes code%0d cyc%0d: D=%h done=%b, want %h %0d", c, i, d4, done, exp_d, (i == 4));
        else pass_cnt++;
        step();
      end
      total_cnt++;
      if (d4 !== 8'h00)
        $display("FAIL all_codes_idle code%0d: D=%h, want 00", c, d4);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d;
    in_valid = 1'b1; code = 3'd2;
    step();
    code = 3'd6;
    total_cnt++;
    if (d4 !== 8'h04 || in_ready !== 1'b1)
      $display("FAIL b2b_first: D=%h in_ready=%b, want 04 1", d4, in_ready);
    else pass_cnt++;
    step();
    in_valid = 1'b0;
    for (int i = 2; i <= 8; i++) begin
      exp_d = (i <= 4) ? 8'h04 : 8'h40;
      total_cnt++;
      if (d4 !== exp_d || done !== (i == 4 || i == 8) || in_ready !== (i > 4))
        $display("FAIL b2b cyc%0d: D=%h done=%b in_ready=%b, want %h %0d %0d",
                 i, d4, done, in_ready, exp_d, (i == 4 || i == 8), (i > 4));
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if (d4 !== 8'h00 || busy !== 1'b0)
      $display("FAIL b2b_end: D=%h busy=%b, want 00 0", d4, busy);
    else pass_cnt++;
  endtask

  task automatic test_bypass_hold1();
    logic [2:0] codes [3];
    logic [7:0] exp_d;
    codes[0] = 3'd7; codes[1] = 3'd0; codes[2] = 3'd3;
    in_valid1 = 1'b1; code1 = codes[0];
    step();
    for (int i = 0; i < 3; i++) begin
      exp_d = 8'h01 << codes[i];
      if (i < 2) code1 = codes[i + 1];
      else in_valid1 = 1'b0;
      total_cnt++;
      if (d1 !== exp_d || done1 !== 1'b1 || busy1 !== 1'b1 || in_ready1 !== 1'b1)
        $display("FAIL bypass cyc%0d: D=%h done=%b busy=%b in_ready=%b, want %h 1 1 1",
                 i, d1, done1, busy1, in_ready1, exp_d);
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if (d1 !== 8'h00 || busy1 !== 1'b0 || done1 !== 1'b0)
      $display("FAIL bypass_end: D=%h busy=%b done=%b, want 00 0 0", d1, busy1, done1);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    in_valid = 1'b1; code = 3'd1;
    step();
    code = 3'd4;
    step();
    in_valid = 1'b0;
    en = 1'b0;
    #1;
    total_cnt++;
    if (d4 !== 8'h02 || done !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL abort_during: D=%h done=%b in_ready=%b, want 02 0 0", d4, done, in_ready);
    else pass_cnt++;
    step();
    total_cnt++;
    if (d4 !== 8'h00 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL abort_after: D=%h busy=%b done=%b, want 00 0 0", d4, busy, done);
    else pass_cnt++;
    en = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1)
      $display("FAIL abort_ready: in_ready=%b, want 1", in_ready);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      step();
      total_cnt++;
      if (d4 !== 8'h00 || done !== 1'b0)
        $display("FAIL abort_no_pending cyc%0d: D=%h done=%b, want 00 0", i, d4, done);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; code = 3'd4;
    step();
    code = 3'd3;
    step();
    in_valid = 1'b0;
    total_cnt++;
    if (d4 !== 8'h10 || in_ready !== 1'b0)
      $display("FAIL rstmid_before: D=%h in_ready=%b, want 10 0", d4, in_ready);
    else pass_cnt++;
    rst = 1'b1;
    step();
    total_cnt++;
    if (d4 !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL rstmid_after: D=%h busy=%b done=%b in_ready=%b, want 00 0 0 0",
               d4, busy, done, in_ready);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1)
      $display("FAIL rstmid_ready: in_ready=%b, want 1", in_ready);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      step();
      total_cnt++;
      if (d4 !== 8'h00 || busy !== 1'b0)
        $display("FAIL rstmid_lost cyc%0d: D=%h busy=%b, want 00 0", i, d4, busy);
      else pass_cnt++;
    end
  endtask

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_basic();
    test_all_codes();
    test_back_to_back();
    test_bypass_hold1();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
